// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort engine: controller state encoding
// and the default data/length width used by controller and datapath.
package sort_pkg;

  localparam int unsigned SORT_DW = 32;

  // 4-bit controller state encoding
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_INIT_C = 4'd1;
  localparam logic [3:0] ST_C_CHK  = 4'd2;
  localparam logic [3:0] ST_INIT_D = 4'd3;
  localparam logic [3:0] ST_D_CHK  = 4'd4;
  localparam logic [3:0] ST_RD1    = 4'd5;
  localparam logic [3:0] ST_RD2    = 4'd6;
  localparam logic [3:0] ST_LD2    = 4'd7;
  localparam logic [3:0] ST_CMP    = 4'd8;
  localparam logic [3:0] ST_WR1    = 4'd9;
  localparam logic [3:0] ST_WR2    = 4'd10;
  localparam logic [3:0] ST_D_INC  = 4'd11;
  localparam logic [3:0] ST_C_INC  = 4'd12;
  localparam logic [3:0] ST_DONE   = 4'd13;

endpackage

// File: rtl/sort_controller.sv
// Moore control FSM for the bubble-sort engine. Sequences the outer (c) and
// inner (d) loops, the read/compare/swap memory traffic and the start/done
// handshake. All strobes are decoded from the state register alone.
module sort_controller
  import sort_pkg::*;
#(
  parameter int unsigned DATAWIDTH = SORT_DW
) (
  input  logic                 ctrl_clk,
  input  logic                 ctrl_rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] d_n,
  input  logic                 c_lt_n_1,
  input  logic                 d_lt_n_c_1,
  input  logic                 t1_gt_t2,
  output logic                 c_clr,
  output logic                 c_ld,
  output logic                 d_clr,
  output logic                 d_ld,
  output logic                 t1_clr,
  output logic                 t1_ld,
  output logic                 t2_clr,
  output logic                 t2_ld,
  output logic                 sel_add,
  output logic                 sel_data,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 busy,
  output logic                 done
);

  localparam logic [DATAWIDTH-1:0] N_MIN = DATAWIDTH'(2);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       short_n;

  // Arrays of length 0 or 1 skip the loops entirely; this also keeps n-1
  // from wrapping in the datapath flags when n is 0.
  assign short_n = (d_n < N_MIN);

  // State register; reset abandons any sort in progress immediately.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (!start)       state_d = ST_IDLE;
        else if (short_n) state_d = ST_DONE;
        else              state_d = ST_INIT_C;
      end
      ST_INIT_C: state_d = ST_C_CHK;
      ST_C_CHK:  state_d = c_lt_n_1   ? ST_INIT_D : ST_DONE;
      ST_INIT_D: state_d = ST_D_CHK;
      ST_D_CHK:  state_d = d_lt_n_c_1 ? ST_RD1    : ST_C_INC;
      ST_RD1:    state_d = ST_RD2;
      ST_RD2:    state_d = ST_LD2;
      ST_LD2:    state_d = ST_CMP;
      ST_CMP:    state_d = t1_gt_t2   ? ST_WR1    : ST_D_INC;
      ST_WR1:    state_d = ST_WR2;
      ST_WR2:    state_d = ST_D_INC;
      ST_D_INC:  state_d = ST_D_CHK;
      ST_C_INC:  state_d = ST_C_CHK;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state register; anything not listed stays 0.
  always_comb begin
    c_clr    = 1'b0;
    c_ld     = 1'b0;
    d_clr    = 1'b0;
    d_ld     = 1'b0;
    t1_clr   = 1'b0;
    t1_ld    = 1'b0;
    t2_clr   = 1'b0;
    t2_ld    = 1'b0;
    sel_add  = 1'b0;
    sel_data = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_INIT_C: begin
        busy   = 1'b1;
        c_clr  = 1'b1;
        t1_clr = 1'b1;
        t2_clr = 1'b1;
      end
      ST_C_CHK:  busy = 1'b1;
      ST_INIT_D: begin
        busy  = 1'b1;
        d_clr = 1'b1;
      end
      ST_D_CHK:  busy = 1'b1;
      // a[d] is requested here and lands in t1 at the end of RD2
      ST_RD1: begin
        busy    = 1'b1;
        sel_add = 1'b0;
        mem_rd  = 1'b1;
      end
      ST_RD2: begin
        busy    = 1'b1;
        sel_add = 1'b1;
        mem_rd  = 1'b1;
        t1_ld   = 1'b1;
      end
      ST_LD2: begin
        busy  = 1'b1;
        t2_ld = 1'b1;
      end
      ST_CMP:    busy = 1'b1;
      ST_WR1: begin
        busy     = 1'b1;
        sel_add  = 1'b0;
        sel_data = 1'b1;
        mem_wr   = 1'b1;
      end
      ST_WR2: begin
        busy     = 1'b1;
        sel_add  = 1'b1;
        sel_data = 1'b0;
        mem_wr   = 1'b1;
      end
      ST_D_INC: begin
        busy = 1'b1;
        d_ld = 1'b1;
      end
      ST_C_INC: begin
        busy = 1'b1;
        c_ld = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sort_controller.sv
// Bench for sort_controller: a small behavioural datapath and memory close
// the loop so that whole sorts can be run and their results compared
// against hand-computed cycle counts, write sequences and final contents.
module tb_sort_controller;
  import sort_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] d_n;
  logic        c_lt_n_1, d_lt_n_c_1, t1_gt_t2;
  logic        c_clr, c_ld, d_clr, d_ld;
  logic        t1_clr, t1_ld, t2_clr, t2_ld;
  logic        sel_add, sel_data, mem_rd, mem_wr, busy, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  sort_controller #(.DATAWIDTH(32)) dut (
    .ctrl_clk   (clk),
    .ctrl_rst_n (rst_n),
    .start      (start),
    .d_n        (d_n),
    .c_lt_n_1   (c_lt_n_1),
    .d_lt_n_c_1 (d_lt_n_c_1),
    .t1_gt_t2   (t1_gt_t2),
    .c_clr      (c_clr),
    .c_ld       (c_ld),
    .d_clr      (d_clr),
    .d_ld       (d_ld),
    .t1_clr     (t1_clr),
    .t1_ld      (t1_ld),
    .t2_clr     (t2_clr),
    .t2_ld      (t2_ld),
    .sel_add    (sel_add),
    .sel_data   (sel_data),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural datapath + memory ----------------
  logic [31:0] mem [0:7];
  logic [31:0] init_vals [0:7];
  logic        load_req;
  logic [31:0] c_r, d_r, t1_r, t2_r, rdata;
  logic [31:0] addr, wdata;

  assign addr       = d_r + {31'd0, sel_add};
  assign wdata      = sel_data ? t2_r : t1_r;
  assign c_lt_n_1   = (c_r < d_n - 32'd1);
  assign d_lt_n_c_1 = (d_r < d_n - c_r - 32'd1);
  assign t1_gt_t2   = (t1_r > t2_r);

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 8; i++) mem[i] <= init_vals[i];
    end else if (mem_wr) begin
      mem[addr[2:0]] <= wdata;
    end
    if (mem_rd) rdata <= mem[addr[2:0]];
    if (c_clr) c_r <= 32'd0; else if (c_ld) c_r <= c_r + 32'd1;
    if (d_clr) d_r <= 32'd0; else if (d_ld) d_r <= d_r + 32'd1;
    if (t1_clr) t1_r <= 32'd0; else if (t1_ld) t1_r <= rdata;
    if (t2_clr) t2_r <= 32'd0; else if (t2_ld) t2_r <= rdata;
  end

  // ---------------- activity monitor ----------------
  logic        mon_clr;
  int          mon_cyc, n_wr, n_rd, n_done, n_ld, excl_err;
  logic [31:0] wr_addr [0:31];
  logic [31:0] wr_data [0:31];
  int          wr_cyc  [0:31];

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_cyc = 0; n_wr = 0; n_rd = 0; n_done = 0; n_ld = 0; excl_err = 0;
    end else begin
      mon_cyc++;
      if (mem_wr && n_wr < 32) begin
        wr_addr[n_wr] = addr;
        wr_data[n_wr] = wdata;
        wr_cyc[n_wr]  = mon_cyc;
        n_wr++;
      end
      if (mem_rd) n_rd++;
      if (done) n_done++;
      if (c_ld || d_ld || c_clr || d_clr) n_ld++;
      if ((mem_rd && mem_wr) || (c_clr && c_ld) || (d_clr && d_ld) ||
          (t1_clr && t1_ld) || (t2_clr && t2_ld)) excl_err++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_mem(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
    init_vals[0] = a0; init_vals[1] = a1; init_vals[2] = a2; init_vals[3] = a3;
    for (int i = 4; i < 8; i++) init_vals[i] = 32'hdead_0000 + 32'(i);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
  endtask

  // Starts a sort; on return we are #1 after the edge that sampled start.
  task automatic kick(input logic [31:0] n, input logic hold);
    d_n   = n;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Cycle 1 is the state right after start was sampled; bounded wait.
  task automatic wait_done(output int cyc, output int busy_err);
    cyc = 1;
    busy_err = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (busy !== 1'b1) busy_err++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    logic [13:0] outs;
    rst_n = 1'b0;
    #12;
    outs = {c_clr, c_ld, d_clr, d_ld, t1_clr, t1_ld, t2_clr, t2_ld,
            sel_add, sel_data, mem_rd, mem_wr, busy, done};
    total_cnt++;
    if (outs !== 14'd0) $display("FAIL reset_outputs: got %b want 0", outs);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // reset in the middle of WR1 of the first swap of {4,3,2,1}
    load_mem(32'd4, 32'd3, 32'd2, 32'd1);
    clear_mon();
    kick(32'd4, 1'b0);
    cyc = 0;
    while (!(mem_wr === 1'b1 && sel_data === 1'b1) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++;
    if (cyc >= 100) $display("FAIL reset_reach_wr1: got timeout want WR1");
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    outs = {c_clr, c_ld, d_clr, d_ld, t1_clr, t1_ld, t2_clr, t2_ld,
            sel_add, sel_data, mem_rd, mem_wr, busy, done};
    total_cnt++;
    if (outs !== 14'd0) $display("FAIL reset_async_outputs: got %b want 0", outs);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (n_wr !== 0) $display("FAIL reset_no_write: got %0d writes want 0", n_wr);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== ST_IDLE || busy !== 1'b0)
      $display("FAIL reset_idle: got state %0d busy %b want %0d 0", dut.state_q, busy, ST_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_n2_sorted();
    int cyc, berr;
    load_mem(32'd5, 32'd9, 32'd0, 32'd0);
    clear_mon();
    kick(32'd2, 1'b0);
    wait_done(cyc, berr);
    total_cnt++;
    if (cyc !== 13) $display("FAIL n2_sorted_latency: got %0d want 13", cyc);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (n_wr !== 0 || mem[0] !== 32'd5 || mem[1] !== 32'd9)
      $display("FAIL n2_sorted_result: got wr %0d mem %0d,%0d want 0 5,9", n_wr, mem[0], mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_n2_swap();
    int cyc, berr;
    load_mem(32'd9, 32'd5, 32'd0, 32'd0);
    clear_mon();
    kick(32'd2, 1'b0);
    wait_done(cyc, berr);
    total_cnt++;
    if (cyc !== 15) $display("FAIL n2_swap_latency: got %0d want 15", cyc);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (n_wr !== 2) $display("FAIL n2_swap_count: got %0d want 2", n_wr);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'd5 ||
        wr_addr[1] !== 32'd1 || wr_data[1] !== 32'd9 || wr_cyc[1] !== wr_cyc[0] + 1)
      $display("FAIL n2_swap_writes: got a%0d=%0d a%0d=%0d dcyc %0d want a0=5 a1=9 dcyc 1",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_cyc[1] - wr_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (mem[0] !== 32'd5 || mem[1] !== 32'd9)
      $display("FAIL n2_swap_mem: got %0d,%0d want 5,9", mem[0], mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_n4_reverse();
    int cyc, berr;
    load_mem(32'd4, 32'd3, 32'd2, 32'd1);
    clear_mon();
    kick(32'd4, 1'b0);
    wait_done(cyc, berr);
    total_cnt++;
    if (cyc !== 63) $display("FAIL n4_latency: got %0d want 63", cyc);
    else pass_cnt++;
    total_cnt++;
    if (berr !== 0) $display("FAIL n4_busy: got %0d low cycles want 0", berr);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL n4_busy_in_done: got %b want 0", busy);
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total_cnt++;
    if (n_wr !== 12 || n_done !== 1)
      $display("FAIL n4_counts: got wr %0d done %0d want 12 1", n_wr, n_done);
    else pass_cnt++;
    total_cnt++;
    if (mem[0] !== 32'd1 || mem[1] !== 32'd2 || mem[2] !== 32'd3 || mem[3] !== 32'd4)
      $display("FAIL n4_mem: got %0d,%0d,%0d,%0d want 1,2,3,4", mem[0], mem[1], mem[2], mem[3]);
    else pass_cnt++;
    total_cnt++;
    if (excl_err !== 0) $display("FAIL exclusivity: got %0d violations want 0", excl_err);
    else pass_cnt++;
  endtask

  task automatic test_short();
    logic [31:0] lens [0:1];
    lens[0] = 32'd0;
    lens[1] = 32'd1;
    for (int k = 0; k < 2; k++) begin
      load_mem(32'd8, 32'd6, 32'd0, 32'd0);
      clear_mon();
      kick(lens[k], 1'b0);
      total_cnt++;
      if (done !== 1'b1 || busy !== 1'b0)
        $display("FAIL short_n%0d_done: got done %b busy %b want 1 0", k, done, busy);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (done !== 1'b0 || n_done !== 1)
        $display("FAIL short_n%0d_pulse: got done %b pulses %0d want 0 1", k, done, n_done);
      else pass_cnt++;
      total_cnt++;
      if (n_rd !== 0 || n_wr !== 0 || n_ld !== 0)
        $display("FAIL short_n%0d_quiet: got rd %0d wr %0d ld %0d want 0 0 0", k, n_rd, n_wr, n_ld);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_held();
    int cyc, berr;
    load_mem(32'd9, 32'd5, 32'd0, 32'd0);
    clear_mon();
    kick(32'd2, 1'b1);
    wait_done(cyc, berr);
    total_cnt++;
    if (cyc !== 15) $display("FAIL held_latency: got %0d want 15", cyc);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL held_idle: got busy %b done %b want 0 0", busy, done);
    else pass_cnt++;
    start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || n_done !== 1 || n_wr !== 2)
      $display("FAIL held_no_restart: got busy %b done %0d wr %0d want 0 1 2", busy, n_done, n_wr);
    else pass_cnt++;

    load_mem(32'd7, 32'd7, 32'd1, 32'd0);
    clear_mon();
    kick(32'd3, 1'b0);
    wait_done(cyc, berr);
    total_cnt++;
    if (cyc !== 33) $display("FAIL dup_latency: got %0d want 33", cyc);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (n_wr !== 4 || mem[0] !== 32'd1 || mem[1] !== 32'd7 || mem[2] !== 32'd7)
      $display("FAIL dup_result: got wr %0d mem %0d,%0d,%0d want 4 1,7,7", n_wr, mem[0], mem[1], mem[2]);
    else pass_cnt++;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    d_n      = 32'd0;
    load_req = 1'b0;
    mon_clr  = 1'b1;
    test_reset();
    test_n2_sorted();
    test_n2_swap();
    test_n4_reverse();
    test_short();
    test_start_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
